lut_neuron_layer: RTL and testbench

- Parametrised successor to the fixed single-neuron truth-table ROMs: NUM_NEURONS neurons, each an IN_BITS-address, OUT_BITS-wide table.
- Tables live in distributed RAM and are loaded at runtime over a config port, so they are not baked in at synthesis.
- Inference path is a one-stage valid/ready pipeline.
- Sits between quantised activation layers in the latency-optimised network; one instance per layer.

---
 rtl/lut_neuron_pkg.sv | 17 +
 rtl/lut_neuron_ram.sv | 39 +++
 rtl/lut_neuron_layer.sv | 160 ++++++++++++++++
 tb/tb_lut_neuron_layer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lut_neuron_pkg.sv
// Shared state type, parameter defaults and table-depth helper for the LUT neuron layer.
package lut_neuron_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int DEF_NUM_NEURONS = 4;
    localparam int DEF_IN_BITS     = 6;
    localparam int DEF_OUT_BITS    = 1;

    function automatic int table_depth(input int in_bits);
        return 1 << in_bits;
    endfunction

endpackage

// File: rtl/lut_neuron_ram.sv
// One neuron truth table: distributed RAM, sync write, async read.
// Second read port exists only when LUT_NEURON_READBACK_EN is defined.
module lut_neuron_ram
    import lut_neuron_pkg::*;
#(
    parameter int IN_BITS  = DEF_IN_BITS,
    parameter int OUT_BITS = DEF_OUT_BITS
) (
    input  logic                i_clk,
    input  logic                i_we,
    input  logic [IN_BITS-1:0]  i_waddr,
    input  logic [OUT_BITS-1:0] i_wdata,
    input  logic [IN_BITS-1:0]  i_raddr,
    output logic [OUT_BITS-1:0] o_rdata
`ifdef LUT_NEURON_READBACK_EN
    ,
    input  logic [IN_BITS-1:0]  i_rb_addr,
    output logic [OUT_BITS-1:0] o_rb_data
`endif
);

    localparam int DEPTH = table_depth(IN_BITS);

    // Contents are deliberately unreset; the layer's clear sweep initialises them.
    logic [OUT_BITS-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

`ifdef LUT_NEURON_READBACK_EN
    assign o_rb_data = r_mem[i_rb_addr];
`endif

endmodule

// File: rtl/lut_neuron_layer.sv
// Layer of runtime-loadable LUT neurons with a one-stage valid/ready path.
// Optional table readback port: LUT_NEURON_READBACK_EN.
module lut_neuron_layer
    import lut_neuron_pkg::*;
#(
    parameter int NUM_NEURONS = DEF_NUM_NEURONS,
    parameter int IN_BITS     = DEF_IN_BITS,
    parameter int OUT_BITS    = DEF_OUT_BITS,
    localparam int NB = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_NEURONS*IN_BITS-1:0]  in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_NEURONS*OUT_BITS-1:0] out_data,
    input  logic                            cfg_we,
    input  logic [NB-1:0]                   cfg_neuron,
    input  logic [IN_BITS-1:0]              cfg_addr,
    input  logic [OUT_BITS-1:0]             cfg_wdata,
    input  logic                            cfg_clear,
    output logic                            cfg_ready,
    output logic                            busy
`ifdef LUT_NEURON_READBACK_EN
    ,
    input  logic                            cfg_re,
    output logic [OUT_BITS-1:0]             cfg_rdata,
    output logic                            cfg_rvalid
`endif
);

    localparam int DEPTH = table_depth(IN_BITS);
    localparam logic [IN_BITS-1:0] LAST = IN_BITS'(DEPTH - 1);

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic [IN_BITS-1:0]              r_clr_cnt;
    logic [IN_BITS-1:0]              w_clr_cnt_nxt;
    logic                            w_run;
    logic                            w_accept;
    logic                            w_cfg_wr;
    logic [IN_BITS-1:0]              w_waddr;
    logic [OUT_BITS-1:0]             w_wdata;
    logic [NUM_NEURONS*OUT_BITS-1:0] w_lookup;
    logic [NUM_NEURONS*OUT_BITS-1:0] r_out_data;
    logic                            r_out_valid;

    assign w_run     = (r_state == RUN);
    assign in_ready  = w_run && (!r_out_valid || out_ready);
    assign cfg_ready = w_run;
    assign busy      = !w_run;
    assign w_accept  = in_valid && in_ready;
    assign w_cfg_wr  = cfg_we && cfg_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        unique case (r_state)
            CLEAR: begin
                w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                if (r_clr_cnt == LAST) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (cfg_clear) begin
                    w_state_nxt   = CLEAR;
                    w_clr_cnt_nxt = '0;
                end
            end
        endcase
    end

    // The sweep owns the write port; config writes only land in RUN.
    assign w_waddr = w_run ? cfg_addr : r_clr_cnt;
    assign w_wdata = w_run ? cfg_wdata : '0;

`ifdef LUT_NEURON_READBACK_EN
    logic [NUM_NEURONS*OUT_BITS-1:0] w_rb;
    logic [OUT_BITS-1:0]             w_rb_sel;
    logic [OUT_BITS-1:0]             r_rdata;
    logic                            r_rvalid;
`endif

    for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_nrn
        logic w_we;
        assign w_we = !w_run || (w_cfg_wr && (cfg_neuron == NB'(n)));

        lut_neuron_ram #(
            .IN_BITS  (IN_BITS),
            .OUT_BITS (OUT_BITS)
        ) u_ram (
            .i_clk     (clk),
            .i_we      (w_we),
            .i_waddr   (w_waddr),
            .i_wdata   (w_wdata),
            .i_raddr   (in_data[n*IN_BITS +: IN_BITS]),
            .o_rdata   (w_lookup[n*OUT_BITS +: OUT_BITS])
`ifdef LUT_NEURON_READBACK_EN
            ,
            .i_rb_addr (cfg_addr),
            .o_rb_data (w_rb[n*OUT_BITS +: OUT_BITS])
`endif
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_lookup;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef LUT_NEURON_READBACK_EN
    // Out-of-range neuron indices match no slot and read back as zero.
    always_comb begin
        w_rb_sel = '0;
        for (int n = 0; n < NUM_NEURONS; n++) begin
            if (cfg_neuron == NB'(n)) begin
                w_rb_sel = w_rb[n*OUT_BITS +: OUT_BITS];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= cfg_re && cfg_ready;
            if (cfg_re && cfg_ready) begin
                r_rdata <= w_rb_sel;
            end
        end
    end

    assign cfg_rdata  = r_rdata;
    assign cfg_rvalid = r_rvalid;
`endif

endmodule

// File: tb/tb_lut_neuron_layer.sv
// Randomised bench for lut_neuron_layer against a table/queue reference model.
module tb_lut_neuron_layer;

    localparam int NN    = 4;
    localparam int IB    = 6;
    localparam int OB    = 1;
    localparam int NB    = 2;
    localparam int DEPTH = 1 << IB;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [NN*IB-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [NN*OB-1:0]  out_data;
    logic              cfg_we;
    logic [NB-1:0]     cfg_neuron;
    logic [IB-1:0]     cfg_addr;
    logic [OB-1:0]     cfg_wdata;
    logic              cfg_clear;
    logic              cfg_ready;
    logic              busy;
`ifdef LUT_NEURON_READBACK_EN
    logic              cfg_re;
    logic [OB-1:0]     cfg_rdata;
    logic              cfg_rvalid;
    logic              rb_v;
    logic [OB-1:0]     rb_d;
`endif

    int n_total = 0;
    int n_bad   = 0;

    logic [OB-1:0]    tbl [NN][DEPTH];
    logic [NN*OB-1:0] q [$];
    int               clr_left;

    always #5 clk = ~clk;

    lut_neuron_layer #(
        .NUM_NEURONS (NN),
        .IN_BITS     (IB),
        .OUT_BITS    (OB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .cfg_we     (cfg_we),
        .cfg_neuron (cfg_neuron),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_clear  (cfg_clear),
        .cfg_ready  (cfg_ready),
        .busy       (busy)
`ifdef LUT_NEURON_READBACK_EN
        ,
        .cfg_re     (cfg_re),
        .cfg_rdata  (cfg_rdata),
        .cfg_rvalid (cfg_rvalid)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NN*OB-1:0] lookup(input logic [NN*IB-1:0] d);
        logic [NN*OB-1:0] r;
        r = '0;
        for (int n = 0; n < NN; n++) begin
            r[n*OB +: OB] = tbl[n][d[n*IB +: IB]];
        end
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        clr_left = DEPTH;
        for (int n = 0; n < NN; n++)
            for (int a = 0; a < DEPTH; a++)
                tbl[n][a] = '0;
`ifdef LUT_NEURON_READBACK_EN
        rb_v = 1'b0;
        rb_d = '0;
`endif
    endtask

    task automatic idle();
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;
        cfg_we     = 1'b0;
        cfg_neuron = '0;
        cfg_addr   = '0;
        cfg_wdata  = '0;
        cfg_clear  = 1'b0;
`ifdef LUT_NEURON_READBACK_EN
        cfg_re     = 1'b0;
`endif
    endtask

    task automatic rand_in();
        in_valid  = ($urandom_range(0, 3) != 0);
        for (int n = 0; n < NN; n++)
            in_data[n*IB +: IB] = IB'($urandom_range(0, 7));
        out_ready = ($urandom_range(0, 9) < 7);
        cfg_we    = ($urandom_range(0, 9) < 3);
        cfg_neuron = NB'($urandom_range(0, NN - 1));
        cfg_addr  = ($urandom_range(0, 3) == 0) ? IB'($urandom_range(0, DEPTH - 1))
                                                : IB'($urandom_range(0, 7));
        cfg_wdata = OB'($urandom);
        cfg_clear = ($urandom_range(0, 299) == 0);
`ifdef LUT_NEURON_READBACK_EN
        cfg_re    = ($urandom_range(0, 3) == 0);
`endif
    endtask

    // Check outputs before the edge, then advance the model across it.
    task automatic tick();
        logic exp_ir;
        @(negedge clk);
        chk("busy", 32'(busy), 32'(clr_left != 0));
        chk("cfg_ready", 32'(cfg_ready), 32'(clr_left == 0));
        exp_ir = (clr_left == 0) && (q.size() == 0 || out_ready);
        chk("in_ready", 32'(in_ready), 32'(exp_ir));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) chk("out_data", 32'(out_data), 32'(q[0]));
`ifdef LUT_NEURON_READBACK_EN
        chk("rvalid", 32'(cfg_rvalid), 32'(rb_v));
        if (rb_v) chk("rdata", 32'(cfg_rdata), 32'(rb_d));
        rb_v = cfg_re && (clr_left == 0);
        if (rb_v) rb_d = (int'(cfg_neuron) < NN) ? tbl[cfg_neuron][cfg_addr] : '0;
`endif
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        if (in_valid && exp_ir) q.push_back(lookup(in_data));
        if (clr_left != 0) begin
            clr_left--;
        end else begin
            if (cfg_we && int'(cfg_neuron) < NN) tbl[cfg_neuron][cfg_addr] = cfg_wdata;
            if (cfg_clear) begin
                for (int n = 0; n < NN; n++)
                    for (int a = 0; a < DEPTH; a++)
                        tbl[n][a] = '0;
                clr_left = DEPTH;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int guard;
        idle();
        rst_n = 1'b0;
        model_reset();
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) tick();
        chk("sweep_busy", 32'(busy), 32'd0);
        chk("sweep_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = 24'h3cf0a5;
        tick();
        chk("post_rst_zero", 32'(out_data), 32'd0);

        idle();
        cfg_we = 1'b1; cfg_neuron = 2'd2; cfg_addr = 6'b011000; cfg_wdata = 1'b1;
        tick();
        idle();
        in_valid = 1'b1;
        in_data  = 24'(6'b011000) << (2 * IB);
        tick();
        chk("n2_lookup", 32'(out_data), 32'b0100);

        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = (i % 2 == 0) ? (24'(6'b011000) << (2 * IB)) : 24'h0;
            out_ready = !(i >= 2 && i < 5);
            tick();
        end

        idle();
        in_valid = 1'b1; in_data = 24'd5;
        cfg_we = 1'b1; cfg_neuron = 2'd0; cfg_addr = 6'd5; cfg_wdata = 1'b1;
        tick();
        chk("collide_old", 32'(out_data[0]), 32'd0);
        cfg_we = 1'b0;
        tick();
        chk("collide_new", 32'(out_data[0]), 32'd1);

`ifdef LUT_NEURON_READBACK_EN
        idle();
        cfg_we = 1'b1; cfg_neuron = 2'd3; cfg_addr = 6'd63; cfg_wdata = 1'b1;
        tick();
        cfg_we = 1'b0; cfg_re = 1'b1;
        tick();
        chk("rb_valid", 32'(cfg_rvalid), 32'd1);
        chk("rb_data", 32'(cfg_rdata), 32'd1);
`endif

        idle();
        tick();
        in_valid = 1'b1; in_data = 24'(6'b011000) << (2 * IB); out_ready = 1'b0;
        tick();
        in_valid = 1'b0; cfg_clear = 1'b1;
        tick();
        cfg_clear = 1'b0;
        chk("clr_busy", 32'(busy), 32'd1);
        chk("clr_hold", 32'(out_data), 32'b0100);
        tick();
        out_ready = 1'b1;
        cfg_we = 1'b1; cfg_neuron = 2'd1; cfg_addr = 6'd9; cfg_wdata = 1'b1;
        tick();
        chk("clr_drained", 32'(out_valid), 32'd0);
        guard = 0;
        while (clr_left != 0 && guard < 200) begin
            tick();
            guard++;
        end
        chk("clr_bound", 32'(guard < 200), 32'd1);
        chk("clr_done", 32'(busy), 32'd0);
        idle();
        for (int a = 0; a < DEPTH; a++) begin
            in_valid = 1'b1;
            in_data  = {4{6'(a)}};
            tick();
        end
        chk("clr_zero", 32'(out_data), 32'd0);

        for (int i = 0; i < 2000; i++) begin
            rand_in();
            tick();
        end

        idle();
        in_valid = 1'b1;
        out_ready = 1'b0;
        guard = 0;
        while (clr_left != 0 && guard < 200) begin
            tick();
            guard++;
        end
        tick();
        rst_n = 1'b0;
        #2;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd1);
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        model_reset();
        idle();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) tick();
        for (int i = 0; i < 400; i++) begin
            rand_in();
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
